// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT0  = 2'd1,
        ARB_GNT1  = 2'd2,
        ARB_ABORT = 2'd3
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stalled-cycle counter for the arbiter; flags a hung bus cycle once the
// count reaches TIMEOUT_CYCLES.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic stall_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stall stops once the bus is forced idle at timeout, so no saturation needed.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (stall_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone B4 classic arbiter with cycle-granular grants.
// Define WB_ARB_TIMEOUT_EN to add the hung-cycle watchdog and ARB_ABORT state.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_wb_cyc_i,
    input  logic                m0_wb_stb_i,
    input  logic                m0_wb_we_i,
    input  logic [WB_ADR_W-1:0] m0_wb_adr_i,
    input  logic [WB_DAT_W-1:0] m0_wb_dat_i,
    input  logic [WB_SEL_W-1:0] m0_wb_sel_i,
    output logic [WB_DAT_W-1:0] m0_wb_dat_o,
    output logic                m0_wb_ack_o,
    output logic                m0_wb_err_o,
    input  logic                m1_wb_cyc_i,
    input  logic                m1_wb_stb_i,
    input  logic                m1_wb_we_i,
    input  logic [WB_ADR_W-1:0] m1_wb_adr_i,
    input  logic [WB_DAT_W-1:0] m1_wb_dat_i,
    input  logic [WB_SEL_W-1:0] m1_wb_sel_i,
    output logic [WB_DAT_W-1:0] m1_wb_dat_o,
    output logic                m1_wb_ack_o,
    output logic                m1_wb_err_o,
    output logic                s_wb_cyc_o,
    output logic                s_wb_stb_o,
    output logic                s_wb_we_o,
    output logic [WB_ADR_W-1:0] s_wb_adr_o,
    output logic [WB_DAT_W-1:0] s_wb_dat_o,
    output logic [WB_SEL_W-1:0] s_wb_sel_o,
    input  logic [WB_DAT_W-1:0] s_wb_dat_i,
    input  logic                s_wb_ack_i,
    input  logic                s_wb_err_i,
    output logic [1:0]          owner_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       enter_gnt;
    logic       gsel;
    logic       g_cyc;

    // Read data is broadcast, but held low while in reset like every other output.
    assign m0_wb_dat_o = rst ? '0 : s_wb_dat_i;
    assign m1_wb_dat_o = rst ? '0 : s_wb_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_timeout;
    logic wd_stall;
    logic wd_clr;

    assign wd_stall = s_wb_cyc_o & s_wb_stb_o & ~s_wb_ack_i & ~s_wb_err_i;
    assign wd_clr   = enter_gnt | s_wb_ack_i | s_wb_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .stall_i   (wd_stall),
        .timeout_o (wd_timeout)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W, enter_gnt};
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        enter_gnt   = 1'b0;
        gsel        = 1'b0;
        g_cyc       = 1'b0;
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_we_o   = 1'b0;
        s_wb_adr_o  = '0;
        s_wb_dat_o  = '0;
        s_wb_sel_o  = '0;
        m0_wb_ack_o = 1'b0;
        m1_wb_ack_o = 1'b0;
        m0_wb_err_o = 1'b0;
        m1_wb_err_o = 1'b0;
        owner_o     = OWN_NONE;
        case (state_q)
            ARB_IDLE: begin
                // On contention the master that did not own the bus last wins.
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = last_q ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_wb_cyc_i) begin
                    state_d = ARB_GNT0;
                end else if (m1_wb_cyc_i) begin
                    state_d = ARB_GNT1;
                end
                enter_gnt = (state_d != ARB_IDLE);
            end
            ARB_GNT0, ARB_GNT1: begin
                gsel    = (state_q == ARB_GNT1);
                g_cyc   = gsel ? m1_wb_cyc_i : m0_wb_cyc_i;
                owner_o = gsel ? OWN_M1 : OWN_M0;
`ifdef WB_ARB_TIMEOUT_EN
                if (wd_timeout) begin
                    m0_wb_err_o = ~gsel;
                    m1_wb_err_o = gsel;
                    last_d      = gsel;
                    state_d     = ARB_ABORT;
                end else
`endif
                begin
                    s_wb_cyc_o  = g_cyc;
                    s_wb_stb_o  = gsel ? m1_wb_stb_i : m0_wb_stb_i;
                    s_wb_we_o   = gsel ? m1_wb_we_i  : m0_wb_we_i;
                    s_wb_adr_o  = gsel ? m1_wb_adr_i : m0_wb_adr_i;
                    s_wb_dat_o  = gsel ? m1_wb_dat_i : m0_wb_dat_i;
                    s_wb_sel_o  = gsel ? m1_wb_sel_i : m0_wb_sel_i;
                    m0_wb_ack_o = ~gsel & s_wb_ack_i;
                    m1_wb_ack_o = gsel & s_wb_ack_i;
                    m0_wb_err_o = ~gsel & s_wb_err_i;
                    m1_wb_err_o = gsel & s_wb_err_i;
                    if (!g_cyc) begin
                        state_d = ARB_IDLE;
                        last_d  = gsel;
                    end
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ARB_ABORT: begin
                // last_q already names the aborted master.
                if (!(last_q ? m1_wb_cyc_i : m0_wb_cyc_i)) begin
                    state_d = ARB_IDLE;
                end
            end
`endif
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random traffic against a reference model.
module tb_wb_arbiter2;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_i;
    logic        s_ack, s_err;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_wb_cyc_i(m_cyc[0]), .m0_wb_stb_i(m_stb[0]), .m0_wb_we_i(m_we[0]),
        .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_dat[0]), .m0_wb_sel_i(m_sel[0]),
        .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o), .m0_wb_err_o(m0_err_o),
        .m1_wb_cyc_i(m_cyc[1]), .m1_wb_stb_i(m_stb[1]), .m1_wb_we_i(m_we[1]),
        .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_dat[1]), .m1_wb_sel_i(m_sel[1]),
        .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o), .m1_wb_err_o(m1_err_o),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel),
        .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
        .owner_o(owner)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        for (int n = 0; n < 2; n++) begin
            m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
            m_adr[n] = '0;   m_dat[n] = '0;   m_sel[n] = '0;
        end
        s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0;
    endtask

    task automatic settle;
        idle_all();
        repeat (3) tick();
    endtask

    task automatic do_reset;
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [143:0] all_o;
        idle_all();
        rst = 1'b1;
        s_ack = 1'b1; s_dat_i = 32'h5A5A_5A5A;
        #2;
        all_o = {s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, m0_ack_o, m1_ack_o,
                 m0_err_o, m1_err_o, owner, m0_dat_o, m1_dat_o};
        checks++;
        if (all_o !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", all_o);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL reset_idle: owner %b s_cyc %b required 00/0", owner, s_cyc);
        end
    endtask

    task automatic test_single_read;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[0] = 32'h0000_1000; m_sel[0] = 4'hF;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            errors++; $display("FAIL read_latency: s_cyc %b required 0 before grant edge", s_cyc);
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b1 || owner !== 2'b01 || s_adr !== 32'h0000_1000 || s_we !== 1'b0) begin
            errors++; $display("FAIL read_grant: cyc %b owner %b adr %h we %b required 1/01/00001000/0",
                               s_cyc, owner, s_adr, s_we);
        end
        tick();
        tick();
        s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL read_ack: m0_ack %b dat %h m1_ack %b required 1/deadbeef/0",
                               m0_ack_o, m0_dat_o, m1_ack_o);
        end
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin
            errors++; $display("FAIL read_release: owner %b required 00", owner);
        end
        settle();
    endtask

    task automatic test_contention;
        do_reset();
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++; $display("FAIL contend_first: owner %b acks %b%b required 01 and m0 only",
                               owner, m1_ack_o, m0_ack_o);
        end
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL contend_gap: owner %b s_cyc %b required 00/0", owner, s_cyc);
        end
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (owner !== 2'b10 || s_cyc !== 1'b1 || m1_ack_o !== 1'b1) begin
            errors++; $display("FAIL contend_second: owner %b s_cyc %b m1_ack %b required 10/1/1",
                               owner, s_cyc, m1_ack_o);
        end
        tick();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01) begin
            errors++; $display("FAIL contend_third: owner %b required 01", owner);
        end
        settle();
    endtask

    task automatic test_m1_write;
        tick();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_adr[1] = 32'h8000_0000; m_dat[1] = 32'h0000_00FF; m_sel[1] = 4'hF;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[0] = 32'h0000_2000; m_dat[0] = 32'h1234_5678; m_sel[0] = 4'h3;
        for (int i = 0; i < 4; i++) begin
            s_ack = (i == 2);
            @(negedge clk);
            checks++;
            if ({s_adr, s_dat_o, s_sel, s_we} !== {32'h8000_0000, 32'h0000_00FF, 4'hF, 1'b1}
                || owner !== 2'b10 || m0_ack_o !== 1'b0 || m1_ack_o !== (i == 2)) begin
                errors++; $display("FAIL m1_write_bus: adr %h dat %h sel %h we %b owner %b acks %b%b required 80000000/000000ff/f/1/10 m1 only",
                                   s_adr, s_dat_o, s_sel, s_we, owner, m1_ack_o, m0_ack_o);
            end
            tick();
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL m1_write_gap: owner %b m0_ack %b required 00/0", owner, m0_ack_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || s_adr !== 32'h0000_2000 || s_sel !== 4'h3) begin
            errors++; $display("FAIL m1_write_handoff: owner %b adr %h sel %h required 01/00002000/3",
                               owner, s_adr, s_sel);
        end
        settle();
    endtask

    task automatic test_reset_mid;
        logic [143:0] all_o;
        tick();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_0040;
        tick();
        s_ack = 1'b1; s_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (m1_ack_o !== 1'b1 || owner !== 2'b10) begin
            errors++; $display("FAIL rstmid_pre: m1_ack %b owner %b required 1/10", m1_ack_o, owner);
        end
        #1 rst = 1'b1;
        #1;
        all_o = {s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, m0_ack_o, m1_ack_o,
                 m0_err_o, m1_err_o, owner, m0_dat_o, m1_dat_o};
        checks++;
        if (all_o !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got %h required 0", all_o);
        end
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin
            errors++; $display("FAIL rstmid_idle: owner %b required 00", owner);
        end
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01) begin
            errors++; $display("FAIL rstmid_contend: owner %b required 01", owner);
        end
        settle();
    endtask

    task automatic test_watchdog;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_3000;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            checks++;
            if (m0_err_o !== 1'b0 || s_cyc !== 1'b1) begin
                errors++; $display("FAIL wd_stall_%0d: err %b s_cyc %b required 0/1", i, m0_err_o, s_cyc);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL wd_pulse: m0_err %b m1_err %b s_cyc %b required 1/0/0",
                               m0_err_o, m1_err_o, s_cyc);
        end
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (m0_err_o !== 1'b0 || s_cyc !== 1'b0 || owner !== 2'b00) begin
                errors++; $display("FAIL wd_abort_%0d: err %b s_cyc %b owner %b required 0/0/00",
                                   i, m0_err_o, s_cyc, owner);
            end
        end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (owner !== 2'b10) begin
            errors++; $display("FAIL wd_last_owner: owner %b required 10", owner);
        end
`else
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if (m0_err_o !== 1'b0 || s_cyc !== 1'b1 || owner !== 2'b01) begin
                errors++; $display("FAIL nowd_hold_%0d: err %b s_cyc %b owner %b required 0/1/01",
                                   i, m0_err_o, s_cyc, owner);
            end
            tick();
        end
`endif
        settle();
    endtask

    task automatic test_random;
        int          mo;
        int          ml;
        int          prev;
        int          waits;
        logic        rsp_ack, rsp_err, resp;
        logic [1:0]  exp_owner;
        logic [70:0] exp_bus;
        logic [3:0]  exp_resp;
        do_reset();
        mo = -1; ml = 1; waits = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            rsp_ack = s_ack; rsp_err = s_err; prev = mo;
            if (mo < 0) begin
                if (m_cyc[0] && m_cyc[1]) mo = 1 - ml;
                else if (m_cyc[0]) mo = 0;
                else if (m_cyc[1]) mo = 1;
            end else if (!m_cyc[mo]) begin
                ml = mo; mo = -1;
            end
            #1;
            for (int n = 0; n < 2; n++) begin
                if (m_cyc[n]) begin
                    if (prev == n && (rsp_ack || rsp_err)) begin
                        if ($urandom_range(2) == 0) begin
                            m_adr[n] = $urandom & 32'hFFFF_FFFC; m_dat[n] = $urandom;
                            m_we[n] = 1'($urandom); m_sel[n] = 4'($urandom);
                        end else begin
                            m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
                        end
                    end
                end else if ($urandom_range(3) == 0) begin
                    m_cyc[n] = 1'b1; m_stb[n] = 1'b1;
                    m_adr[n] = $urandom & 32'hFFFF_FFFC; m_dat[n] = $urandom;
                    m_we[n] = 1'($urandom); m_sel[n] = 4'($urandom);
                end
            end
            resp = (waits >= 3) || ($urandom_range(7) < 3);
            s_err = resp && ($urandom_range(7) == 0);
            s_ack = resp && !s_err;
            s_dat_i = $urandom;
            if (mo >= 0 && m_cyc[mo]) waits = resp ? 0 : waits + 1;
            else waits = 0;
            @(negedge clk);
            exp_owner = 2'b00; exp_bus = '0; exp_resp = '0;
            if (mo >= 0) begin
                exp_owner = (mo == 0) ? 2'b01 : 2'b10;
                exp_bus = {m_cyc[mo], m_stb[mo], m_we[mo], m_adr[mo], m_dat[mo], m_sel[mo]};
                exp_resp = (mo == 0) ? {1'b0, s_ack, 1'b0, s_err} : {s_ack, 1'b0, s_err, 1'b0};
            end
            checks++;
            if (owner !== exp_owner) begin
                errors++; $display("FAIL rnd_owner c%0d: got %b required %b", c, owner, exp_owner);
            end
            checks++;
            if ({s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel} !== exp_bus) begin
                errors++; $display("FAIL rnd_bus c%0d: got %h required %h", c,
                                   {s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel}, exp_bus);
            end
            checks++;
            if ({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o} !== exp_resp) begin
                errors++; $display("FAIL rnd_resp c%0d: got %b required %b", c,
                                   {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, exp_resp);
            end
            checks++;
            if (m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) begin
                errors++; $display("FAIL rnd_rdata c%0d: got %h/%h required %h", c, m0_dat_o, m1_dat_o, s_dat_i);
            end
        end
        settle();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_contention();
        test_m1_write();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
